// File: rtl/spi_master_engine_pkg.sv
// Shared SPI engine types: one-hot state encoding, error codes and the coprocessor packet
// widths the processor packs against the engine's MaxTxWidth.
package SpiPkg;
  localparam int OpcodeWidth        = 8;
  localparam int OperandWidth       = 16;
  localparam int ShamtWidth         = 4;
  localparam int AluPacketWidth     = OpcodeWidth + 2 * OperandWidth;
  localparam int MulPacketWidth     = OpcodeWidth + 2 * OperandWidth;
  localparam int ShifterPacketWidth = OpcodeWidth + OperandWidth + ShamtWidth;
  localparam int MaxPacketWidth     = 40;

  typedef logic [6:0] spi_state_t;
  localparam spi_state_t ST_IDLE      = 7'b000_0001;
  localparam spi_state_t ST_SEND      = 7'b000_0010;
  localparam spi_state_t ST_SENDING   = 7'b000_0100;
  localparam spi_state_t ST_RECEIVE   = 7'b000_1000;
  localparam spi_state_t ST_RECEIVING = 7'b001_0000;
  localparam spi_state_t ST_DONE      = 7'b010_0000;
  localparam spi_state_t ST_FAIL      = 7'b100_0000;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BAD_REQ = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ABORT   = 2'd3
  } spi_error_t;

  // Keeps index/counter vectors at least one bit wide for degenerate parameter values.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction
endpackage

// File: rtl/spi_master_engine_if.sv
// Request/response bundle between the EXECUTE stage (master modport) and the SPI engine
// (slave modport). Signal prefixes are from the engine's point of view.
interface spi_master_engine_if
  import SpiPkg::*;
#(
  parameter int NumSlaves  = 3,
  parameter int MaxTxWidth = MaxPacketWidth,
  parameter int RxWidth    = 16
);
  localparam int SlaveWidth = clog2_min1(NumSlaves);
  localparam int LenWidth   = clog2_min1(MaxTxWidth + 1);

  logic                  i_start;
  logic [SlaveWidth-1:0] i_slave;
  logic [LenWidth-1:0]   i_tx_len;
  logic [MaxTxWidth-1:0] i_tx_data;
  logic                  i_abort;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_error;
  spi_error_t            o_error_code;
  logic [RxWidth-1:0]    o_rx_data;

  modport master (
    output i_start, i_slave, i_tx_len, i_tx_data, i_abort,
    input  o_busy, o_done, o_error, o_error_code, o_rx_data
  );

  modport slave (
    input  i_start, i_slave, i_tx_len, i_tx_data, i_abort,
    output o_busy, o_done, o_error, o_error_code, o_rx_data
  );
endinterface

// File: rtl/spi_master_engine_wait_timer.sv
// Slave-wait timer: counts cycles spent waiting for an acknowledge and flags when the
// count reaches TimeoutCycles. TimeoutCycles == 0 disables the timeout entirely.
module spi_wait_timer
  import SpiPkg::*;
#(
  parameter int TimeoutCycles = 255
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int Width = clog2_min1(TimeoutCycles + 1);
  localparam logic [Width-1:0] Terminal = Width'(TimeoutCycles);

  logic [Width-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (TimeoutCycles != 0) && (r_count == Terminal);
endmodule

// File: rtl/spi_master_engine.sv
// SPI master engine: serialises one variable-length request to a selected coprocessor and
// collects its fixed-width reply, with wait-phase timeout, abort and error reporting.
//   state     | meaning
//   IDLE      | waiting for i_start; validates the request
//   SEND      | slave selected, mosi high, waiting for miso low (ready)
//   SENDING   | shifting out r_len request bits, LSB first
//   RECEIVE   | mosi low, waiting for miso high (start bit)
//   RECEIVING | shifting in RxWidth reply bits, LSB first
//   DONE      | one-cycle completion pulse, selects released
//   FAIL      | one-cycle error pulse, selects released
module spi_master_engine
  import SpiPkg::*;
#(
  parameter int NumSlaves     = 3,
  parameter int MaxTxWidth    = MaxPacketWidth,
  parameter int RxWidth       = 16,
  parameter int TimeoutCycles = 255
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  spi_master_engine_if.slave   io_req,
  output logic                 o_sclk,
  output logic [NumSlaves-1:0] o_nss,
  output logic                 o_mosi,
  input  logic                 i_miso
);
  localparam int SlaveWidth = clog2_min1(NumSlaves);
  localparam int LenWidth   = clog2_min1(MaxTxWidth + 1);
  localparam int CntWidth   = clog2_min1((MaxTxWidth > RxWidth) ? MaxTxWidth : RxWidth);

  spi_state_t            r_state;
  logic [SlaveWidth-1:0] r_slave;
  logic [LenWidth-1:0]   r_len;
  logic [MaxTxWidth-1:0] r_tx_shift;
  logic [RxWidth-1:0]    r_rx_shift;
  logic [RxWidth-1:0]    r_rx_data;
  logic [CntWidth-1:0]   r_bit_cnt;
  logic                  r_done;
  logic                  r_error;
  spi_error_t            r_error_code;

  logic w_req_valid;
  logic w_accept;
  logic w_last_tx_bit;
  logic w_last_rx_bit;
  logic w_selected;
  logic w_timer_clear;
  logic w_timer_en;
  logic w_timer_expired;

  assign w_req_valid = (int'(io_req.i_slave) < NumSlaves) &&
                       (io_req.i_tx_len != '0) &&
                       (int'(io_req.i_tx_len) <= MaxTxWidth);
  assign w_accept      = (r_state == ST_IDLE) && io_req.i_start && w_req_valid;
  assign w_last_tx_bit = (int'(r_bit_cnt) + 1 == int'(r_len));
  assign w_last_rx_bit = (int'(r_bit_cnt) == RxWidth - 1);
  assign w_selected    = |(r_state & (ST_SEND | ST_SENDING | ST_RECEIVE | ST_RECEIVING));

  // The wait timer restarts at each of the two handshake phases.
  assign w_timer_clear = w_accept || ((r_state == ST_SENDING) && w_last_tx_bit);
  assign w_timer_en    = !io_req.i_abort &&
                         (((r_state == ST_SEND) && i_miso) ||
                          ((r_state == ST_RECEIVE) && !i_miso));

  spi_wait_timer #(
    .TimeoutCycles(TimeoutCycles)
  ) u_wait_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_expired(w_timer_expired)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_slave      <= '0;
      r_len        <= '0;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_rx_data    <= '0;
      r_bit_cnt    <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_error_code <= ERR_NONE;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_req.i_start) begin
            if (w_req_valid) begin
              r_state      <= ST_SEND;
              r_slave      <= io_req.i_slave;
              r_len        <= io_req.i_tx_len;
              r_tx_shift   <= io_req.i_tx_data;
              r_bit_cnt    <= '0;
              r_error_code <= ERR_NONE;
            end else begin
              r_error      <= 1'b1;
              r_error_code <= ERR_BAD_REQ;
            end
          end
        end
        ST_SEND: begin
          if (io_req.i_abort) begin
            r_state      <= ST_FAIL;
            r_error      <= 1'b1;
            r_error_code <= ERR_ABORT;
          end else if (!i_miso) begin
            r_state <= ST_SENDING;
          end else if (w_timer_expired) begin
            r_state      <= ST_FAIL;
            r_error      <= 1'b1;
            r_error_code <= ERR_TIMEOUT;
          end
        end
        ST_SENDING: begin
          if (io_req.i_abort) begin
            r_state      <= ST_FAIL;
            r_error      <= 1'b1;
            r_error_code <= ERR_ABORT;
          end else begin
            r_tx_shift <= r_tx_shift >> 1;
            if (w_last_tx_bit) begin
              r_bit_cnt <= '0;
              r_state   <= ST_RECEIVE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_RECEIVE: begin
          if (io_req.i_abort) begin
            r_state      <= ST_FAIL;
            r_error      <= 1'b1;
            r_error_code <= ERR_ABORT;
          end else if (i_miso) begin
            r_state   <= ST_RECEIVING;
            r_bit_cnt <= '0;
          end else if (w_timer_expired) begin
            r_state      <= ST_FAIL;
            r_error      <= 1'b1;
            r_error_code <= ERR_TIMEOUT;
          end
        end
        ST_RECEIVING: begin
          if (io_req.i_abort) begin
            r_state      <= ST_FAIL;
            r_error      <= 1'b1;
            r_error_code <= ERR_ABORT;
          end else begin
            // Shadow shift register: o_rx_data only changes on a complete reply.
            r_rx_shift <= {i_miso, r_rx_shift[RxWidth-1:1]};
            if (w_last_rx_bit) begin
              r_rx_data <= {i_miso, r_rx_shift[RxWidth-1:1]};
              r_done    <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_FAIL: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_nss = '1;
    if (w_selected) begin
      o_nss[r_slave] = 1'b0;
    end
  end

  always_comb begin
    o_mosi = 1'b0;
    if (r_state == ST_SEND) begin
      o_mosi = 1'b1;
    end else if (r_state == ST_SENDING) begin
      o_mosi = r_tx_shift[0];
    end
  end

  assign o_sclk              = i_clock;
  assign io_req.o_busy       = (r_state != ST_IDLE);
  assign io_req.o_done       = r_done;
  assign io_req.o_error      = r_error;
  assign io_req.o_error_code = r_error_code;
  assign io_req.o_rx_data    = r_rx_data;
endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine: stimulus pushes expected done/error pulses into a
// queue, a negedge monitor pops and compares them against the DUT.
module tb_spi_master_engine;
  import SpiPkg::*;

  localparam int NS  = 3;
  localparam int MTX = 40;
  localparam int RXW = 16;
  localparam int TMO = 255;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [15:0] rx;
    int          cyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk;
  logic [2:0]  nss;
  logic        mosi;
  logic        miso  = 1'b1;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          nss_low[NS];
  int          busy_cnt = 0;
  int          pulse_cnt = 0;
  logic [15:0] model_rx;
  exp_t        exp_q[$];
  exp_t        mon_e;

  always #5 clk = ~clk;

  spi_master_engine_if #(.NumSlaves(NS), .MaxTxWidth(MTX), .RxWidth(RXW)) bus ();

  spi_master_engine #(
    .NumSlaves(NS), .MaxTxWidth(MTX), .RxWidth(RXW), .TimeoutCycles(TMO)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .io_req (bus),
    .o_sclk (sclk),
    .o_nss  (nss),
    .o_mosi (mosi),
    .i_miso (miso)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NS; k++) if (!nss[k]) nss_low[k]++;
      if (bus.o_busy) busy_cnt++;
      if (bus.o_done || bus.o_error) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: done=%0b error=%0b at cycle %0d, required none",
                   bus.o_done, bus.o_error, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind", {bus.o_done, bus.o_error}, mon_e.is_err ? 64'd1 : 64'd2);
          check("error_code", bus.o_error_code, mon_e.code);
          check("rx_data", bus.o_rx_data, mon_e.rx);
          check("pulse_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  // Full transaction with a scripted slave; abort_bit >= 0 aborts at that RECEIVING bit.
  task automatic run_txn(input int slave, input int len, input logic [39:0] data,
                         input int send_wait, input logic [15:0] resp,
                         input int abort_bit, input bit poke_start);
    int          t0;
    int          mosi_bad;
    exp_t        e;
    logic [2:0]  sel;
    int          low_req;
    t0 = cyc;
    for (int k = 0; k < NS; k++) nss_low[k] = 0;
    sel = 3'b111;
    sel[slave] = 1'b0;
    e.is_err = (abort_bit >= 0);
    e.code   = (abort_bit >= 0) ? ERR_ABORT : ERR_NONE;
    e.rx     = (abort_bit >= 0) ? model_rx : resp;
    e.cyc    = (abort_bit >= 0) ? t0 + send_wait + len + 4 + abort_bit
                                : t0 + send_wait + len + RXW + 3;
    low_req  = (abort_bit >= 0) ? send_wait + len + 3 + abort_bit
                                : send_wait + len + RXW + 2;
    exp_q.push_back(e);
    if (abort_bit < 0) model_rx = resp;

    bus.i_start = 1'b1; bus.i_slave = 2'(slave); bus.i_tx_len = 6'(len);
    bus.i_tx_data = data; miso = 1'b1;
    @(posedge clk); #1; bus.i_start = 1'b0;
    @(negedge clk);
    check("send_nss", nss, sel);
    check("send_mosi", mosi, 1'b1);
    check("send_busy", bus.o_busy, 1'b1);
    repeat (send_wait) begin @(posedge clk); #1; end
    miso = 1'b0;
    @(posedge clk); #1;
    mosi_bad = 0;
    for (int i = 0; i < len; i++) begin
      if (poke_start && i == 2) begin bus.i_start = 1'b1; bus.i_slave = 2'd1; end
      @(negedge clk);
      if (mosi !== data[i]) mosi_bad++;
      @(posedge clk); #1; bus.i_start = 1'b0;
    end
    check("mosi_bit_errors", mosi_bad, 0);
    @(negedge clk);
    check("receive_mosi", mosi, 1'b0);
    miso = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < RXW; i++) begin
      miso = resp[i];
      if (i == abort_bit) bus.i_abort = 1'b1;
      @(posedge clk); #1;
      bus.i_abort = 1'b0;
      if (i == abort_bit) break;
    end
    miso = 1'b1;
    @(posedge clk); #1;
    check("pulse_seen", exp_q.size(), 0);
    for (int k = 0; k < NS; k++) check("nss_low_cycles", nss_low[k], (k == slave) ? low_req : 0);
  endtask

  task automatic run_timeout(input int slave, input int len, input logic [39:0] data);
    int   t0;
    int   guard;
    exp_t e;
    t0 = cyc;
    for (int k = 0; k < NS; k++) nss_low[k] = 0;
    e.is_err = 1'b1; e.code = ERR_TIMEOUT; e.rx = model_rx; e.cyc = t0 + TMO + 2;
    exp_q.push_back(e);
    bus.i_start = 1'b1; bus.i_slave = 2'(slave); bus.i_tx_len = 6'(len);
    bus.i_tx_data = data; miso = 1'b1;
    @(posedge clk); #1; bus.i_start = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin @(posedge clk); #1; guard++; end
    if (guard >= 400) begin
      n_checks++; n_fail++;
      $display("FAIL timeout_wait: no error pulse within 400 cycles, required one");
      exp_q.delete();
    end
    check("timeout_nss_released", nss, 3'b111);
    check("timeout_nss_low_cycles", nss_low[slave], TMO + 1);
    check("timeout_busy_cleared", bus.o_busy, 1'b0);
  endtask

  task automatic run_bad(input int slave, input int len);
    exp_t e;
    busy_cnt = 0;
    for (int k = 0; k < NS; k++) nss_low[k] = 0;
    e.is_err = 1'b1; e.code = ERR_BAD_REQ; e.rx = model_rx; e.cyc = cyc + 1;
    exp_q.push_back(e);
    bus.i_start = 1'b1; bus.i_slave = 2'(slave); bus.i_tx_len = 6'(len);
    @(posedge clk); #1; bus.i_start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("bad_req_pulse_seen", exp_q.size(), 0);
    check("bad_req_busy_cycles", busy_cnt, 0);
    check("bad_req_nss_activity", nss_low[0] + nss_low[1] + nss_low[2], 0);
  endtask

  initial begin
    int pulses_before;
    bus.i_start = 1'b0; bus.i_slave = '0; bus.i_tx_len = '0;
    bus.i_tx_data = '0; bus.i_abort = 1'b0;
    model_rx = 16'h0000;
    for (int k = 0; k < NS; k++) nss_low[k] = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_nss", nss, 3'b111);
    check("reset_busy", bus.o_busy, 1'b0);
    check("reset_done", bus.o_done, 1'b0);
    check("reset_error", bus.o_error, 1'b0);
    check("reset_error_code", bus.o_error_code, 2'd0);
    check("reset_rx_data", bus.o_rx_data, 16'h0000);
    check("reset_mosi", mosi, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(0, 40, 40'h12_3456_789A, 0, 16'hBEEF, -1, 1'b0);
    run_txn(2, 32, 40'h00_CAFE_1234, 10, 16'h1357, -1, 1'b0);
    run_timeout(1, 8, 40'h00_0000_005A);
    run_bad(3, 8);
    run_bad(0, 0);
    run_bad(1, 41);
    run_txn(1, 4, 40'h00_0000_000A, 0, 16'hFFFF, 5, 1'b0);
    run_txn(0, 16, 40'h00_0000_5A5A, 0, 16'h0F0F, -1, 1'b1);

    // Async reset in the middle of SENDING, after an ignored start.
    bus.i_start = 1'b1; bus.i_slave = 2'd0; bus.i_tx_len = 6'd20;
    bus.i_tx_data = 40'h00_000F_0F0F; miso = 1'b1;
    @(posedge clk); #1; bus.i_start = 1'b0; miso = 1'b0;
    @(posedge clk); #1; bus.i_start = 1'b1; bus.i_slave = 2'd2;
    @(posedge clk); #1; bus.i_start = 1'b0;
    check("busy_after_extra_start", bus.o_busy, 1'b1);
    check("nss_after_extra_start", nss, 3'b110);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_nss", nss, 3'b111);
    check("async_reset_busy", bus.o_busy, 1'b0);
    check("async_reset_done", bus.o_done, 1'b0);
    check("async_reset_error", bus.o_error, 1'b0);
    check("async_reset_error_code", bus.o_error_code, 2'd0);
    check("async_reset_rx_data", bus.o_rx_data, 16'h0000);
    check("async_reset_mosi", mosi, 1'b0);
    model_rx = 16'h0000;
    miso = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    pulses_before = pulse_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("no_pulse_after_reset", pulse_cnt, pulses_before);
    run_txn(1, 8, 40'h00_0000_00C3, 0, 16'h8001, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
